multi_alu_arbiter: RTL and testbench

//   N_CH-channel shared-ALU arbiter, the parametrised successor of the two-channel ALU request selector.

---
 rtl/multi_alu_arb_pkg.sv | 37 +++
 rtl/multi_alu_arbiter_alu_core.sv | 16 +
 rtl/multi_alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_multi_alu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_alu_arb_pkg.sv
// Shared types and ALU helper for the multi-channel ALU arbiter.
// Optional round-robin tie-break is enabled by defining MULTI_ALU_ARB_RR_TIE_EN.
package multi_alu_arb_pkg;

    localparam int unsigned ALU_MAX_W = 64;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_AND = 2'b10;
    localparam op_t OP_OR  = 2'b11;

    // Result of op on a/b truncated to w bits (carry/borrow dropped).
    function automatic logic [ALU_MAX_W-1:0] alu_calc(
        input op_t                  op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input int unsigned          w
    );
        logic [ALU_MAX_W-1:0] r;
        logic [ALU_MAX_W-1:0] mask;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            default: r = a | b;
        endcase
        if (w >= ALU_MAX_W) begin
            mask = '1;
        end else begin
            mask = (ALU_MAX_W'(1) << w) - ALU_MAX_W'(1);
        end
        return r & mask;
    endfunction

endpackage

// File: rtl/multi_alu_arbiter_alu_core.sv
// Combinational ALU used by stage 2 of the multi-channel ALU arbiter.
// Behaviour is independent of MULTI_ALU_ARB_RR_TIE_EN.
module alu_core
    import multi_alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_d_c
);

    assign o_d_c = WIDTH'(alu_calc(i_op, ALU_MAX_W'(i_a), ALU_MAX_W'(i_b), WIDTH));

endmodule

// File: rtl/multi_alu_arbiter.sv
// N_CH-channel shared-ALU arbiter: min-op priority grant, 2-stage pipeline, tagged result port.
// Define MULTI_ALU_ARB_RR_TIE_EN for round-robin tie-break among equal ops (default: lowest index).
module multi_alu_arbiter
    import multi_alu_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned N_CH  = 4,
    localparam int unsigned CH_W  = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       req_valid,
    input  logic [2*N_CH-1:0]     req_op,
    input  logic [WIDTH*N_CH-1:0] req_a,
    input  logic [WIDTH*N_CH-1:0] req_b,
    output logic [N_CH-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_result,
    output logic [CH_W-1:0]       out_ch,
    output logic [1:0]            out_op
);

    localparam int unsigned CHP_W = CH_W + 1;

    op_t              w_op [N_CH];
    logic [WIDTH-1:0] w_a  [N_CH];
    logic [WIDTH-1:0] w_b  [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign w_op[g] = req_op[2*g +: 2];
        assign w_a[g]  = req_a[WIDTH*g +: WIDTH];
        assign w_b[g]  = req_b[WIDTH*g +: WIDTH];
    end

    logic             r_s1_valid;
    op_t              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [CH_W-1:0]  r_s1_ch;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [CH_W-1:0]  r_s2_ch;
    op_t              r_s2_op;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_any_valid;
    logic [CH_W-1:0]  w_grant;
    op_t              w_best_op;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_d;

`ifdef MULTI_ALU_ARB_RR_TIE_EN
    logic [CH_W-1:0]  r_rr_ptr;
`endif

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    // Priority scan: strict '<' keeps the first channel searched among equal ops.
    always_comb begin
        logic [CH_W-1:0]  idx;
        logic [CHP_W-1:0] sum;
        w_any_valid = 1'b0;
        w_grant     = '0;
        w_best_op   = OP_OR;
        idx         = '0;
        sum         = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
`ifdef MULTI_ALU_ARB_RR_TIE_EN
            sum = {1'b0, r_rr_ptr} + CHP_W'(k);
            if (sum >= CHP_W'(N_CH)) begin
                sum = sum - CHP_W'(N_CH);
            end
`else
            sum = CHP_W'(k);
`endif
            idx = sum[CH_W-1:0];
            if (req_valid[idx] && (!w_any_valid || (w_op[idx] < w_best_op))) begin
                w_any_valid = 1'b1;
                w_grant     = idx;
                w_best_op   = w_op[idx];
            end
        end
    end

    assign w_accept = rst_n && w_s1_adv && w_any_valid;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .i_op  (r_s1_op),
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_d_c (w_alu_d)
    );

    // Stage 1 captures the granted request, stage 2 registers the ALU result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_ADD;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_ch     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_ch     <= '0;
            r_s2_op     <= OP_ADD;
`ifdef MULTI_ALU_ARB_RR_TIE_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_any_valid;
                if (w_any_valid) begin
                    r_s1_op <= w_op[w_grant];
                    r_s1_a  <= w_a[w_grant];
                    r_s1_b  <= w_b[w_grant];
                    r_s1_ch <= w_grant;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_result <= w_alu_d;
                    r_s2_ch     <= r_s1_ch;
                    r_s2_op     <= r_s1_op;
                end
            end
`ifdef MULTI_ALU_ARB_RR_TIE_EN
            if (w_accept) begin
                r_rr_ptr <= (w_grant == CH_W'(N_CH - 1)) ? '0 : w_grant + CH_W'(1);
            end
`endif
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_result;
    assign out_ch     = r_s2_ch;
    assign out_op     = r_s2_op;

endmodule

// File: tb/tb_multi_alu_arbiter.sv
// Bench for multi_alu_arbiter (WIDTH=4, N_CH=4): vector table, directed corner cases, random vs model.
// Expectations follow MULTI_ALU_ARB_RR_TIE_EN when it is defined.
module tb_multi_alu_arbiter;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned CH_W  = 2;
`ifdef MULTI_ALU_ARB_RR_TIE_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       req_valid;
    logic [2*N_CH-1:0]     req_op;
    logic [WIDTH*N_CH-1:0] req_a;
    logic [WIDTH*N_CH-1:0] req_b;
    logic [N_CH-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_result;
    logic [CH_W-1:0]       out_ch;
    logic [1:0]            out_op;

    multi_alu_arbiter #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ch     (out_ch),
        .out_op     (out_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int op;
        int res;
        int stamp;
    } item_t;

    typedef struct {
        int ch;
        int op;
        int a;
        int b;
        int exp;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    m_ptr = 0;
    item_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int ref_alu(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) & 15;
            1:       return (a - b) & 15;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    // Winner = smallest (op, search distance) pair among valid channels.
    function automatic int ref_winner(input logic [3:0] v, input logic [7:0] ops, input int ptr);
        int best    = -1;
        int bestkey = 1 << 30;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (v[i]) begin
                int key;
                key = int'(ops[2*i +: 2]) * int'(N_CH) + (RR_EN ? (i - ptr + int'(N_CH)) % int'(N_CH) : i);
                if (key < bestkey) begin
                    bestkey = key;
                    best    = i;
                end
            end
        end
        return best;
    endfunction

    // One clock cycle: check DUT against the model, then advance the model.
    task automatic step(output int acc_ch);
        int    w;
        int    n;
        logic  [3:0] exp_rdy;
        bit    exp_ov;
        bit    dq;
        item_t it;
        acc_ch = -1;
        it     = '{ch: 0, op: 0, res: 0, stamp: 0};
        #1;
        n       = q.size();
        w       = ref_winner(req_valid, req_op, m_ptr);
        exp_rdy = '0;
        if (rst_n && w >= 0 && (n < 2 || out_ready)) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_ov = 1'b0;
        if (n > 0) exp_ov = (q[0].stamp <= cyc - 2);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_result", 32'(out_result), 32'(q[0].res));
            chk("out_ch", 32'(out_ch), 32'(q[0].ch));
            chk("out_op", 32'(out_op), 32'(q[0].op));
        end
        dq = exp_ov && out_ready;
        if (exp_rdy != 4'b0000) begin
            acc_ch   = w;
            it.ch    = w;
            it.op    = int'(req_op[2*w +: 2]);
            it.res   = ref_alu(it.op, int'(req_a[4*w +: 4]), int'(req_b[4*w +: 4]));
            it.stamp = cyc;
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_ptr  = 0;
            acc_ch = -1;
        end else begin
            if (dq) void'(q.pop_front());
            if (acc_ch >= 0) begin
                q.push_back(it);
                m_ptr = (acc_ch + 1) % int'(N_CH);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int ch, input int op, input int a, input int b);
        req_valid[ch]      = 1'b1;
        req_op[2*ch +: 2]  = 2'(op);
        req_a[4*ch +: 4]   = 4'(a);
        req_b[4*ch +: 4]   = 4'(b);
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic do_reset();
        int d;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clr_req();
        step(d);
        step(d);
        rst_n = 1'b1;
    endtask

    vec_t       vecs[10];
    int         acc;
    int         cnt;
    int         exp_g[4];
    logic [3:0] held;
    bit         p_v[4];
    logic [1:0] p_op[4];
    logic [3:0] p_a[4];
    logic [3:0] p_b[4];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clr_req();
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        step(acc);

        // Table of single requests: grant, 2-cycle latency, result, tag
        vecs[0] = '{2, 0, 9, 8, 1};
        vecs[1] = '{0, 1, 3, 5, 14};
        vecs[2] = '{1, 0, 2, 2, 4};
        vecs[3] = '{3, 2, 12, 10, 8};
        vecs[4] = '{1, 3, 5, 10, 15};
        vecs[5] = '{0, 1, 0, 1, 15};
        vecs[6] = '{3, 0, 15, 15, 14};
        vecs[7] = '{2, 2, 15, 3, 3};
        vecs[8] = '{1, 1, 8, 3, 5};
        vecs[9] = '{0, 3, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            clr_req();
            set_req(vecs[i].ch, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            chk("vec_ready", 32'(req_ready), 32'(1) << vecs[i].ch);
            step(acc);
            clr_req();
            step(acc);
            #1;
            chk("vec_out_valid", 32'(out_valid), 32'd1);
            chk("vec_result", 32'(out_result), 32'(vecs[i].exp));
            chk("vec_ch", 32'(out_ch), 32'(vecs[i].ch));
            chk("vec_op", 32'(out_op), 32'(vecs[i].op));
            step(acc);
        end

        // Lower op wins over lower index
        clr_req();
        set_req(0, 1, 3, 5);
        set_req(1, 0, 2, 2);
        #1;
        chk("prio_first", 32'(req_ready), 32'b0010);
        step(acc);
        req_valid[1] = 1'b0;
        #1;
        chk("prio_second", 32'(req_ready), 32'b0001);
        step(acc);
        clr_req();
        #1;
        chk("prio_res1", 32'(out_result), 32'h4);
        chk("prio_ch1", 32'(out_ch), 32'd1);
        step(acc);
        #1;
        chk("prio_res2", 32'(out_result), 32'hE);
        chk("prio_ch2", 32'(out_ch), 32'd0);
        step(acc);
        step(acc);

        // Tie between ch0 and ch3 with equal op
        do_reset();
        if (RR_EN) exp_g = '{0, 3, 0, 3};
        else       exp_g = '{0, 0, 0, 0};
        set_req(0, 2, 7, 5);
        set_req(3, 2, 6, 3);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_grant", 32'(req_ready), 32'(1) << exp_g[k]);
            step(acc);
        end
        clr_req();
        for (int k = 0; k < 3; k++) step(acc);

        // Backpressure: two accepts fill the pipe, then stall
        do_reset();
        out_ready = 1'b0;
        set_req(1, 0, 0, 1);
        cnt  = 0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (req_ready[1]) cnt++;
            if (k == 2) held = out_result;
            if (k == 4) begin
                chk("bp_ready_low", 32'(req_ready), 32'd0);
                chk("bp_hold", 32'(out_result), 32'(held));
            end
            step(acc);
            if (acc == 1) set_req(1, 0, cnt, 1);
        end
        chk("bp_accepts", 32'(cnt), 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_full_accept", 32'(req_ready), 32'b0010);
        chk("bp_res1", 32'(out_result), 32'h1);
        step(acc);
        clr_req();
        #1;
        chk("bp_res2", 32'(out_result), 32'h2);
        step(acc);
        #1;
        chk("bp_valid3", 32'(out_valid), 32'd1);
        chk("bp_res3", 32'(out_result), 32'h3);
        step(acc);
        #1;
        chk("bp_empty", 32'(out_valid), 32'd0);
        step(acc);

        // Reset with both stages full
        do_reset();
        out_ready = 1'b0;
        set_req(0, 0, 1, 1);
        step(acc);
        step(acc);
        clr_req();
        set_req(0, 3, 1, 2);
        set_req(2, 3, 4, 8);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        step(acc);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(out_result), 32'd0);
        chk("mid_rst_ch", 32'(out_ch), 32'd0);
        chk("mid_rst_op", 32'(out_op), 32'd0);
        chk("post_rst_tie", 32'(req_ready), 32'b0001);
        step(acc);
        req_valid[0] = 1'b0;
        step(acc);
        clr_req();
        for (int k = 0; k < 3; k++) step(acc);

        // Single accept then idle
        do_reset();
        set_req(3, 3, 5, 2);
        step(acc);
        clr_req();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("idle_ready", 32'(req_ready), 32'd0);
            if (out_valid) begin
                cnt++;
                chk("idle_result", 32'(out_result), 32'h7);
            end
            step(acc);
        end
        chk("idle_count", 32'(cnt), 32'd1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4; i++) begin
            p_v[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!p_v[i] && ($urandom_range(0, 1) == 1)) begin
                    p_v[i]  = 1'b1;
                    p_op[i] = 2'($urandom);
                    p_a[i]  = 4'($urandom);
                    p_b[i]  = 4'($urandom);
                end
            end
            clr_req();
            for (int i = 0; i < 4; i++) begin
                if (p_v[i]) set_req(i, int'(p_op[i]), int'(p_a[i]), int'(p_b[i]));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step(acc);
            if (acc >= 0) p_v[acc] = 1'b0;
        end
        clr_req();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step(acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
